// File: rtl/dsa_ds_pkg.sv
// Shared types for the downscale job sequencer: job descriptor, FSM states,
// error codes and the descriptor validation rule.
package dsa_ds_pkg;

    typedef struct packed {
        logic [15:0] in_w;
        logic [15:0] in_h;
        logic [15:0] out_w;
        logic [15:0] out_h;
        logic [15:0] inv_scale_q;
    } job_t;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_ZERO_DIM = 2'd1;
    localparam logic [1:0] ERR_TOO_BIG  = 2'd2;
    localparam logic [1:0] ERR_UPSCALE  = 2'd3;

    // 1.0 in Q8.8; anything smaller would be an upscale.
    localparam logic [15:0] INV_ONE = 16'h0100;

    // Validation in priority order: zero dimension, oversize source, upscale.
    function automatic logic [1:0] check_job(input job_t j,
                                             input logic [15:0] w_max,
                                             input logic [15:0] h_max);
        logic [1:0] code;
        code = ERR_NONE;
        if (j.in_w == 16'd0 || j.in_h == 16'd0 || j.out_w == 16'd0 || j.out_h == 16'd0)
            code = ERR_ZERO_DIM;
        else if (j.in_w > w_max || j.in_h > h_max)
            code = ERR_TOO_BIG;
        else if (j.out_w > j.in_w || j.out_h > j.in_h || j.inv_scale_q < INV_ONE)
            code = ERR_UPSCALE;
        return code;
    endfunction

endpackage

// File: rtl/ds_job_fifo.sv
// Synchronous FIFO of job descriptors with a flush that empties it in one cycle.
module ds_job_fifo
    import dsa_ds_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  job_t                     din,
    input  logic                     pop,
    output job_t                     dout,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    job_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    // Flush dominates: nothing enters or leaves in a flush cycle.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Descriptor storage; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointer and occupancy tracking; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/downscale_job_sequencer.sv
// Job sequencer in front of the bilinear downscale core: queues descriptors,
// validates each one, runs the core, and reports cycles, pixels and an irq.
//
// Host handshake: a descriptor is accepted on a rising clk edge where
// job_valid && job_ready; the host holds the descriptor stable while
// job_valid is high and job_ready is low. job_ready never depends on job_valid.
module downscale_job_sequencer
    import dsa_ds_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W_MAX = 64,
    parameter int H_MAX = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     job_valid,
    output logic                     job_ready,
    input  logic [15:0]              job_in_w,
    input  logic [15:0]              job_in_h,
    input  logic [15:0]              job_out_w,
    input  logic [15:0]              job_out_h,
    input  logic [15:0]              job_inv_scale_q,
    input  logic                     flush,
    output logic                     core_start,
    output logic [15:0]              core_in_w,
    output logic [15:0]              core_in_h,
    output logic [15:0]              core_out_w,
    output logic [15:0]              core_out_h,
    output logic [15:0]              core_inv_scale_q,
    input  logic                     core_busy,
    input  logic                     core_done,
    input  logic                     core_wr_valid,
    output logic                     job_done,
    output logic                     job_err,
    output logic [1:0]               err_code,
    output logic [31:0]              job_cycles,
    output logic [31:0]              job_pixels,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     idle,
    output logic                     irq,
    input  logic                     irq_clr,
    output logic [2:0]               dbg_state
);

    localparam logic [15:0] W_MAX_L = 16'(W_MAX);
    localparam logic [15:0] H_MAX_L = 16'(H_MAX);

    seq_state_e  state;
    job_t        cfg;
    job_t        head;
    job_t        in_job;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [1:0]  chk_code;
    logic [31:0] cyc_cnt;
    logic [31:0] pix_cnt;
    logic        counting;

    // Pack the host descriptor fields into a queue entry.
    always_comb begin
        in_job             = '0;
        in_job.in_w        = job_in_w;
        in_job.in_h        = job_in_h;
        in_job.out_w       = job_out_w;
        in_job.out_h       = job_out_h;
        in_job.inv_scale_q = job_inv_scale_q;
    end

    assign job_ready = !fifo_full && !flush;
    assign fifo_push = job_valid && job_ready;
    assign fifo_pop  = (state == S_IDLE) && !fifo_empty && !flush;
    assign chk_code  = check_job(cfg, W_MAX_L, H_MAX_L);
    assign counting  = (state == S_START) || (state == S_RUN);
    assign idle      = (state == S_IDLE) && (q_count == '0);
    assign dbg_state = state;

    assign core_in_w        = cfg.in_w;
    assign core_in_h        = cfg.in_h;
    assign core_out_w       = cfg.out_w;
    assign core_out_h       = cfg.out_h;
    assign core_inv_scale_q = cfg.inv_scale_q;

    ds_job_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (in_job),
        .pop   (fifo_pop),
        .dout  (head),
        .flush (flush),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (q_count)
    );

    // Sequencer FSM: pop, validate, start the core, wait for completion, report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cfg        <= '0;
            core_start <= 1'b0;
            job_done   <= 1'b0;
            job_err    <= 1'b0;
            err_code   <= ERR_NONE;
            job_cycles <= '0;
            job_pixels <= '0;
        end else begin
            job_done <= 1'b0;
            job_err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (fifo_pop) begin
                        cfg   <= head;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (chk_code != ERR_NONE) begin
                        job_err  <= 1'b1;
                        err_code <= chk_code;
                        state    <= S_IDLE;
                    end else begin
                        core_start <= 1'b1;
                        state      <= S_START;
                    end
                end
                S_START: begin
                    // core_done may still be high from the previous job; only busy matters here.
                    if (core_busy) begin
                        core_start <= 1'b0;
                        state      <= S_RUN;
                    end
                end
                S_RUN: begin
                    // No timeout: a stepped core may stall here indefinitely.
                    if (core_done && !core_busy) state <= S_DONE;
                end
                S_DONE: begin
                    job_cycles <= cyc_cnt;
                    job_pixels <= pix_cnt;
                    job_done   <= 1'b1;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Per-job cycle and pixel counters, cleared while validating, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
            pix_cnt <= '0;
        end else if (state == S_CHECK) begin
            cyc_cnt <= '0;
            pix_cnt <= '0;
        end else if (counting) begin
            if (cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
            if (core_wr_valid && pix_cnt != '1) pix_cnt <= pix_cnt + 32'd1;
        end
    end

    // Sticky interrupt: a done/err pulse sets it and wins over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) irq <= 1'b0;
        else        irq <= job_done | job_err | (irq & ~irq_clr);
    end

endmodule

// File: tb/tb_downscale_job_sequencer.sv
// Bench for downscale_job_sequencer with a behavioural core model:
// the core goes busy one cycle after sampling start, stays busy for
// 2*out_w*out_h cycles (one pixel strobe every second cycle), then
// drops busy and raises done. In step mode it advances only on step.
module tb_downscale_job_sequencer;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RUN  = 3'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid;
    logic        job_ready;
    logic [15:0] job_in_w, job_in_h, job_out_w, job_out_h, job_inv_scale_q;
    logic        flush;
    logic        core_start;
    logic [15:0] core_in_w, core_in_h, core_out_w, core_out_h, core_inv_scale_q;
    logic        core_busy, core_done, core_wr_valid;
    logic        job_done, job_err;
    logic [1:0]  err_code;
    logic [31:0] job_cycles, job_pixels;
    logic [2:0]  q_count;
    logic        idle, irq, irq_clr;
    logic [2:0]  dbg_state;

    logic        step_mode;
    logic        step;
    int          busy_left;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int start_cnt = 0;
    logic start_prev = 1'b0;
    int q_peak = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] iw, ih, ow, oh, inv;
        logic        exp_err;
        logic [1:0]  exp_code;
        logic [31:0] exp_pix;
        logic [31:0] exp_cyc;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    downscale_job_sequencer #(.DEPTH(4), .W_MAX(64), .H_MAX(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_in_w(job_in_w), .job_in_h(job_in_h),
        .job_out_w(job_out_w), .job_out_h(job_out_h),
        .job_inv_scale_q(job_inv_scale_q),
        .flush(flush),
        .core_start(core_start),
        .core_in_w(core_in_w), .core_in_h(core_in_h),
        .core_out_w(core_out_w), .core_out_h(core_out_h),
        .core_inv_scale_q(core_inv_scale_q),
        .core_busy(core_busy), .core_done(core_done), .core_wr_valid(core_wr_valid),
        .job_done(job_done), .job_err(job_err), .err_code(err_code),
        .job_cycles(job_cycles), .job_pixels(job_pixels),
        .q_count(q_count), .idle(idle),
        .irq(irq), .irq_clr(irq_clr),
        .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Behavioural core model
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_busy     <= 1'b0;
            core_done     <= 1'b0;
            core_wr_valid <= 1'b0;
            busy_left     <= 0;
        end else begin
            core_wr_valid <= 1'b0;
            if (!core_busy) begin
                if (core_start) begin
                    core_busy <= 1'b1;
                    core_done <= 1'b0;
                    busy_left <= 2 * int'(core_out_w) * int'(core_out_h);
                end
            end else if (!step_mode || step) begin
                core_wr_valid <= (busy_left % 2 == 0);
                busy_left     <= busy_left - 1;
                if (busy_left <= 1) begin
                    core_busy <= 1'b0;
                    core_done <= 1'b1;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d", name, act, exp);
        end
    endtask

    // Event monitor and in-order pixel scoreboard
    always @(negedge clk) begin
        if (job_done) begin
            done_cnt++;
            if (exp_q.size() > 0) begin
                check("sb_pixels", job_pixels, exp_q.pop_front());
            end else begin
                total++;
                bad++;
                $display("FAIL sb_unexpected_done: got=job_done want=none");
            end
        end
        if (job_err) err_cnt++;
        if (core_start && !start_prev) start_cnt++;
        start_prev = core_start;
        if (int'(q_count) > q_peak) q_peak = int'(q_count);
    end

    // Drivers: called at a negedge, return at the negedge after acceptance, job_valid left high
    task automatic push_job(input logic [15:0] iw, ih, ow, oh, inv);
        int guard;
        guard = 0;
        job_in_w = iw; job_in_h = ih; job_out_w = ow; job_out_h = oh; job_inv_scale_q = inv;
        job_valid = 1'b1;
        while (!job_ready && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 500) check("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_result(input int limit, output logic got_done, output logic got_err);
        int n;
        got_done = 1'b0;
        got_err  = 1'b0;
        n = 0;
        while (!got_done && !got_err && n < limit) begin
            @(negedge clk);
            got_done = job_done;
            got_err  = job_err;
            n++;
        end
    endtask

    task automatic wait_start(input string name);
        int n;
        n = 0;
        while (!core_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, core_start}, 32'd1);
    endtask

    task automatic pulse_irq_clr();
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
    endtask

    initial begin
        logic got_done, got_err;
        logic [1:0] last_code;
        int s0, d0, n;

        // Reset
        rst_n = 1'b0; job_valid = 1'b0; flush = 1'b0; irq_clr = 1'b0;
        step_mode = 1'b0; step = 1'b0;
        job_in_w = '0; job_in_h = '0; job_out_w = '0; job_out_h = '0; job_inv_scale_q = '0;
        last_code = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_core_start", {31'd0, core_start}, 32'd0);
        check("rst_job_done", {31'd0, job_done}, 32'd0);
        check("rst_err_code", {30'd0, err_code}, 32'd0);
        check("rst_job_cycles", job_cycles, 32'd0);
        check("rst_q_count", {29'd0, q_count}, 32'd0);
        check("rst_idle", {31'd0, idle}, 32'd1);
        check("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table
        vecs[0] = '{4, 4, 2, 2, 16'h0200, 1'b0, 2'd0, 32'd4, 32'd10};
        vecs[1] = '{4, 4, 0, 2, 16'h0200, 1'b1, 2'd1, 32'd0, 32'd0};
        vecs[2] = '{4, 4, 2, 2, 16'h0200, 1'b0, 2'd0, 32'd4, 32'd10};
        vecs[3] = '{65, 8, 8, 8, 16'h0100, 1'b1, 2'd2, 32'd0, 32'd0};
        vecs[4] = '{4, 4, 8, 8, 16'h0080, 1'b1, 2'd3, 32'd0, 32'd0};
        vecs[5] = '{8, 8, 4, 4, 16'h0200, 1'b0, 2'd0, 32'd16, 32'd34};
        vecs[6] = '{64, 64, 64, 64, 16'h0100, 1'b0, 2'd0, 32'd4096, 32'd8194};
        vecs[7] = '{4, 4, 4, 4, 16'h00FF, 1'b1, 2'd3, 32'd0, 32'd0};
        vecs[8] = '{0, 70, 8, 8, 16'h0080, 1'b1, 2'd1, 32'd0, 32'd0};
        vecs[9] = '{70, 4, 8, 4, 16'h0080, 1'b1, 2'd2, 32'd0, 32'd0};

        for (int i = 0; i < NV; i++) begin
            s0 = start_cnt;
            if (!vecs[i].exp_err) exp_q.push_back(vecs[i].exp_pix);
            push_job(vecs[i].iw, vecs[i].ih, vecs[i].ow, vecs[i].oh, vecs[i].inv);
            job_valid = 1'b0;
            wait_result(20000, got_done, got_err);
            check($sformatf("v%0d_kind", i), {30'd0, got_err, got_done},
                  vecs[i].exp_err ? 32'd2 : 32'd1);
            if (vecs[i].exp_err) begin
                last_code = vecs[i].exp_code;
                check($sformatf("v%0d_code", i), {30'd0, err_code}, {30'd0, last_code});
                check($sformatf("v%0d_no_start", i), start_cnt - s0, 32'd0);
            end else begin
                check($sformatf("v%0d_pixels", i), job_pixels, vecs[i].exp_pix);
                check($sformatf("v%0d_cycles", i), job_cycles, vecs[i].exp_cyc);
                check($sformatf("v%0d_code_held", i), {30'd0, err_code}, {30'd0, last_code});
            end
            @(negedge clk);
            check($sformatf("v%0d_irq", i), {31'd0, irq}, 32'd1);
            pulse_irq_clr();
        end

        // Queued jobs behind a running one: in-order completion, queue depth 3
        q_peak = 0;
        d0 = done_cnt;
        exp_q.push_back(32'd4);
        push_job(4, 4, 2, 2, 16'h0200);
        job_valid = 1'b0;
        wait_start("b2b_lead_start");
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'd16);
            push_job(8, 8, 4, 4, 16'h0200);
        end
        job_valid = 1'b0;
        n = 0;
        while (done_cnt - d0 < 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("b2b_done_count", done_cnt - d0, 32'd4);
        check("b2b_q_peak", q_peak, 32'd3);
        pulse_irq_clr();

        // Stepped core: sequencer waits in RUN until the final step
        step_mode = 1'b1;
        exp_q.push_back(32'd1);
        push_job(2, 2, 1, 1, 16'h0200);
        job_valid = 1'b0;
        wait_start("step_start");
        repeat (30) @(negedge clk);
        check("step_wait_run", {29'd0, dbg_state}, {29'd0, ST_RUN});
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        repeat (10) @(negedge clk);
        check("step_mid_run", {29'd0, dbg_state}, {29'd0, ST_RUN});
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        wait_result(50, got_done, got_err);
        check("step_done", {30'd0, got_err, got_done}, 32'd1);
        check("step_pixels", job_pixels, 32'd1);
        step_mode = 1'b0;
        @(negedge clk);
        pulse_irq_clr();

        // Full queue, then flush while a job runs
        d0 = done_cnt;
        exp_q.push_back(32'd16);
        push_job(8, 8, 4, 4, 16'h0200);
        job_valid = 1'b0;
        wait_start("flush_start");
        for (int k = 0; k < 4; k++) push_job(4, 4, 2, 2, 16'h0200);
        job_valid = 1'b0;
        check("full_q_count", {29'd0, q_count}, 32'd4);
        check("full_ready", {31'd0, job_ready}, 32'd0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_q_count", {29'd0, q_count}, 32'd0);
        check("flush_still_running", {29'd0, dbg_state}, {29'd0, ST_RUN});
        wait_result(200, got_done, got_err);
        check("flush_job_done", {30'd0, got_err, got_done}, 32'd1);
        repeat (20) @(negedge clk);
        check("flush_done_count", done_cnt - d0, 32'd1);
        check("flush_idle", {31'd0, idle}, 32'd1);

        // irq_clr coinciding with a job_done pulse
        pulse_irq_clr();
        check("irq_cleared", {31'd0, irq}, 32'd0);
        exp_q.push_back(32'd4);
        push_job(4, 4, 2, 2, 16'h0200);
        job_valid = 1'b0;
        n = 0;
        while (!job_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        irq_clr = 1'b1;
        @(negedge clk);
        irq_clr = 1'b0;
        check("irq_set_wins", {31'd0, irq}, 32'd1);

        // Asynchronous reset in the middle of a job
        d0 = done_cnt;
        push_job(8, 8, 4, 4, 16'h0200);
        job_valid = 1'b0;
        wait_start("rst_run_start");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_core_start", {31'd0, core_start}, 32'd0);
        check("midrst_job_cycles", job_cycles, 32'd0);
        check("midrst_job_pixels", job_pixels, 32'd0);
        check("midrst_err_code", {30'd0, err_code}, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        check("midrst_core_out_w", {16'd0, core_out_w}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_IDLE});
        check("midrst_idle", {31'd0, idle}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt - d0, 32'd0);
        check("midrst_idle_after", {31'd0, idle}, 32'd1);
        check("sb_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
